// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  vga_pkg
//  Shared 640x480@60 raster constants, state encoding and decode helpers.
//  Used by vga_sync_generator, vga_pixel_shifter and VGA_data_controller.
//  Revision: 1.0
// ============================================================================
package vga_pkg;

   typedef enum logic [1:0] {
      SYNC       = 2'd0,
      BACKPORCH  = 2'd1,
      ACTIVE     = 2'd2,
      FRONTPORCH = 2'd3
   } vga_state_t;

   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_FP    = 16;
   localparam int H_TOTAL = 800;

   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_FP    = 10;
   localparam int V_TOTAL = 525;

   // Region of one axis: sync first, then back porch, visible area, front porch.
   function automatic vga_state_t vga_decode_state(input logic [9:0] cnt,
                                                   input int sync_w,
                                                   input int bp_w,
                                                   input int act_w);
      int c;
      c = int'(cnt);
      if (c < sync_w)                     return SYNC;
      else if (c < sync_w + bp_w)         return BACKPORCH;
      else if (c < sync_w + bp_w + act_w) return ACTIVE;
      else                                return FRONTPORCH;
   endfunction

   // Blank lines report FRONTPORCH so the controller never fetches on them.
   function automatic vga_state_t vga_combine_state(input vga_state_t h_st,
                                                    input vga_state_t v_st);
      return (v_st == ACTIVE) ? h_st : FRONTPORCH;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_shifter.sv
`default_nettype none
// ============================================================================
//  vga_pixel_shifter
//  One-word input buffer plus 32-bit serializer. A word is moved from the
//  buffer into the shift register at the first pixel of every 32-pixel group;
//  a missing word shows black and raises underrun, a word arriving while the
//  buffer is still full is dropped and raises overrun.
//  Revision: 1.0
// ============================================================================
module vga_pixel_shifter (
   input  logic        clk,
   input  logic        rst,
   input  logic        active_i,     // pixel position is inside the visible area
   input  logic [31:0] data_i,
   input  logic        data_en_i,
   output logic        word_ready_o,
   output logic        pixel_o,
   output logic        underrun_o,
   output logic        overrun_o
);

   logic [31:0] buf_q, buf_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] sr_q, sr_d;
   logic [4:0]  col_q, col_d;
   logic        under_q, under_d;
   logic        over_q, over_d;
   logic        pix_q, pix_d;
   logic        load;

   assign load = active_i && (col_q == 5'd0);

   // Next-state: load/shift the serializer, then accept or drop an incoming word.
   always_comb begin
      buf_d       = buf_q;
      buf_valid_d = buf_valid_q;
      sr_d        = sr_q;
      col_d       = col_q;
      under_d     = under_q;
      over_d      = over_q;
      pix_d       = 1'b0;

      if (active_i) begin
         col_d = col_q + 5'd1;   // natural wrap 31 -> 0 starts the next word
         if (col_q == 5'd0) begin
            if (buf_valid_q) begin
               sr_d        = buf_q;
               buf_valid_d = 1'b0;
            end else begin
               sr_d    = '0;
               under_d = 1'b1;
            end
         end else begin
            sr_d = {sr_q[30:0], 1'b0};
         end
         pix_d = sr_d[31];
      end else begin
         col_d = 5'd0;
      end

      // A load in the same cycle frees the buffer, so the new word is kept.
      if (data_en_i) begin
         if (!buf_valid_q || load) begin
            buf_d       = data_i;
            buf_valid_d = 1'b1;
         end else begin
            over_d = 1'b1;
         end
      end
   end

   // Buffer, serializer and sticky flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q       <= '0;
         buf_valid_q <= 1'b0;
         sr_q        <= '0;
         col_q       <= '0;
         under_q     <= 1'b0;
         over_q      <= 1'b0;
         pix_q       <= 1'b0;
      end else begin
         buf_q       <= buf_d;
         buf_valid_q <= buf_valid_d;
         sr_q        <= sr_d;
         col_q       <= col_d;
         under_q     <= under_d;
         over_q      <= over_d;
         pix_q       <= pix_d;
      end
   end

   assign word_ready_o = !buf_valid_q;
   assign pixel_o      = pix_q;
   assign underrun_o   = under_q;
   assign overrun_o    = over_q;

endmodule
`default_nettype wire

// File: rtl/vga_sync_generator.sv
`default_nettype none
// ============================================================================
//  vga_sync_generator
//  Free-running 640x480@60 raster timing: horizontal/vertical counters, region
//  decode for the data controller, active-low syncs and 1-bpp serial pixels.
//  Syncs and pixel data lag the counters by one clock.
//  Revision: 1.0
// ============================================================================
module vga_sync_generator #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_to_VGA,
   input  logic        data_en,
   output logic [9:0]  h_count,
   output logic [9:0]  v_count,
   output logic [1:0]  VGA_state,
   output logic        word_ready,
   output logic        hsync,
   output logic        vsync,
   output logic        pixel_data,
   output logic        underrun,
   output logic        overrun
);
   import vga_pkg::*;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   vga_state_t state_q, state_d;
   vga_state_t h_state, v_state;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       line_active;

   // Counter advance and decode; VGA_state is precomputed so it tracks the counters.
   always_comb begin
      h_d = h_q + 10'd1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = 10'd0;
         v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end

      h_state = vga_decode_state(h_q, H_SYNC, H_BP, H_ACTIVE);
      v_state = vga_decode_state(v_q, V_SYNC, V_BP, V_ACTIVE);

      state_d = vga_combine_state(vga_decode_state(h_d, H_SYNC, H_BP, H_ACTIVE),
                                  vga_decode_state(v_d, V_SYNC, V_BP, V_ACTIVE));

      hsync_d = (h_state != SYNC);
      vsync_d = (v_state != SYNC);
   end

   // Counter, state and sync registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q     <= '0;
         v_q     <= '0;
         state_q <= FRONTPORCH;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         state_q <= state_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign line_active = (h_state == ACTIVE) && (v_state == ACTIVE);

   vga_pixel_shifter u_shifter (
      .clk          (clk),
      .rst          (rst),
      .active_i     (line_active),
      .data_i       (data_to_VGA),
      .data_en_i    (data_en),
      .word_ready_o (word_ready),
      .pixel_o      (pixel_data),
      .underrun_o   (underrun),
      .overrun_o    (overrun)
   );

   assign h_count   = h_q;
   assign v_count   = v_q;
   assign VGA_state = state_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;

endmodule
`default_nettype wire

// File: doc/vga_sync_generator.md
# vga_sync_generator

Free-running 640x480 @ 60 Hz raster timing generator with a 1-bpp pixel serializer. It drives `h_count` and `VGA_state` into `VGA_data_controller`, and it consumes that block's `data_to_VGA`/`data_en` word stream. It produces `hsync`, `vsync` and the serial `pixel_data` sent to the VGA DAC/pins.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- Porch and sync widths are fixed constants in `vga_pkg`, not parameters.
- `clk` in 1: 25 MHz pixel clock.
- `rst` in 1: reset, asynchronous, active-high.
- `data_to_VGA` in 32: pixel word from the data controller, MSB = leftmost pixel.
- `data_en` in 1: `data_to_VGA` valid this cycle.
- `h_count` out 10: horizontal counter, 0..799.
- `v_count` out 10: vertical counter, 0..524.
- `VGA_state` out 2: 0 SYNC, 1 BACKPORCH, 2 ACTIVE, 3 FRONTPORCH.
- `word_ready` out 1: word buffer empty, so a new word can be accepted.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `pixel_data` out 1: serial pixel, 1 = white.
- `underrun` out 1: sticky flag, cleared only by `rst`.
- `overrun` out 1: sticky flag, cleared only by `rst`.

## Operation
- **Horizontal counter.** `h_count` increments every clk and wraps 799 -> 0. `v_count` increments on each `h_count` wrap and wraps 524 -> 0.
- **h_state decode** from `h_count`:
  - 0-95: SYNC
  - 96-143: BACKPORCH
  - 144-783: ACTIVE
  - 784-799: FRONTPORCH
- **v_state decode** from `v_count`:
  - 0-1: SYNC
  - 2-34: BACKPORCH
  - 35-514: ACTIVE
  - 515-524: FRONTPORCH
- **VGA_state.** Equals h_state when v_state is ACTIVE; otherwise it is forced to FRONTPORCH (3). The controller therefore never fetches on blank lines.
- **Sync outputs.** `hsync` is 0 while h_state is SYNC, 1 otherwise. `vsync` is 0 while v_state is SYNC, 1 otherwise.
- **Word buffer.** A single 32-bit `buf` with a `buf_valid` flag. When `data_en` = 1, `data_to_VGA` is written into `buf` and `buf_valid` is set.
- **Shift register load.** A 32-bit shift register `sr` and a 5-bit `col` counter.
  - Condition: an ACTIVE/ACTIVE cycle with `col` = 0.
  - If `buf_valid` = 1: `sr` <= `buf` and `buf_valid` is cleared.
  - If `buf_valid` = 0: `sr` <= 0 and `underrun` is set.
- **Shift register output.** On every other ACTIVE/ACTIVE cycle, `sr` shifts left by 1. `col` increments in ACTIVE/ACTIVE and resets to 0 outside ACTIVE.
- **pixel_data.** Equals `sr[31]` after a load or shift; 0 outside active. That gives 20 words per line.
- **Simultaneous load and `data_en`.** The old `buf` goes to `sr`, the new word goes to `buf`, and `buf_valid` stays 1.
- **Overrun.** `data_en` while `buf_valid` = 1 with no load this cycle: the word is dropped, `buf` is kept and `overrun` is set.
- **word_ready** = !`buf_valid`.

## Timing
- **Reset values.**
  - `h_count` = 0, `v_count` = 0.
  - `VGA_state` = 3 (v is SYNC, so not active).
  - `hsync` = 0, `vsync` = 0.
  - `pixel_data` = 0, `word_ready` = 1.
  - `underrun` = 0, `overrun` = 0.
  - `buf`, `sr` and `col` = 0.
- **Counter outputs.** `h_count`, `v_count` and `VGA_state` are registered outputs of the counter flops.
- **Sync and pixel pipeline.** `hsync`, `vsync` and `pixel_data` are registered one stage later. Pixel column c (0..639) of line L appears on `pixel_data` in the cycle where `h_count` = 145 + c and `v_count` = 35 + L. Sync edges are delayed by the same 1 cycle.
- **Word fetch deadline.** The word for columns 32k..32k+31 must arrive (`data_en`) no later than the cycle where `h_count` = 143 + 32k.
- **Frame period.** 800 x 525 = 420000 clk. The counters wrap at 799/524 with no skipped or repeated value.
- **Mid-frame reset.** Asserting `rst` mid-frame forces all reset values immediately (async). Counting restarts from 0/0 on the first clk after release.

## Structure
- `vga_pkg` holds:
  - a `vga_state_t` enum (SYNC=0, BACKPORCH=1, ACTIVE=2, FRONTPORCH=3);
  - `H_SYNC`=96, `H_BP`=48, `H_FP`=16, `H_TOTAL`=800;
  - `V_SYNC`=2, `V_BP`=33, `V_FP`=10, `V_TOTAL`=525;
  - the same package is shared with `VGA_data_controller`.
- One sub-module, `vga_pixel_shifter`, contains `buf`, `sr`, `col` and the overrun/underrun logic. The top level contains the counters, state decode and sync generation.

## Test plan
- **Reset and sync timing.** Release `rst`, run 1 frame.
  - `hsync` low for exactly 96 clk per line.
  - `vsync` low for exactly 1600 clk.
  - `h_count` wraps at 799 and `v_count` at 524.
- **VGA_state sequence.** Check `VGA_state` at `v_count` = 35:
  - 0 at h = 0..95, 1 at 96..143, 2 at 144..783, 3 at 784..799.
  - At `v_count` = 10 it is 3 for the whole line.
- **Pixel pattern.** Feed `data_en` with 32'hFFFFFFFF, 0 and 32'h6AAA5556, alternating, each at `h_count` = 140 + 32k.
  - Line 0: `pixel_data` is 1 for h = 145..176 and 0 for 177..208.
  - The third word serializes as 0110101010...0110.
- **Underrun.** Withhold the word for k = 3.
  - `pixel_data` is 0 for h = 241..272.
  - `underrun` rises and stays 1 until `rst`.
- **Overrun.** Two `data_en` pulses 1 cycle apart during BACKPORCH.
  - `overrun` = 1.
  - The first word is the one shown at column 0.
- **Mid-frame reset.** Assert `rst` asynchronously at `v_count` = 200, `h_count` = 400.
  - All outputs take reset values within the same cycle.
  - After release, `h_count` counts 0, 1, 2.
